// File: rtl/prog_loader.sv
// prog_loader: loads a header-prefixed 16-bit word stream into a DEPTH x 16 register image.
// Define PROG_LOADER_CLEAR_EN to zero-fill the unused tail of the image before it is released.
module prog_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_data,
  output logic                   prog_loading,
  output logic [DEPTH-1:0][15:0] data_frames_out,
  output logic                   load_done,
  output logic                   len_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
`ifdef PROG_LOADER_CLEAR_EN
    S_CLEAR,
`endif
    S_DONE
  } state_e;

  localparam logic [15:0]   MAX_LEN16 = 16'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
`ifdef PROG_LOADER_CLEAR_EN
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
`endif

  state_e                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [AW-1:0]          len_q, len_d;
  logic                   len_err_q, len_err_d;
  logic                   in_ready_q, in_ready_d;
  logic                   prog_loading_q, prog_loading_d;
  logic                   load_done_q, load_done_d;
  logic [DEPTH-1:0][15:0] img_q;

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [15:0]            wr_data;
  logic                   hdr_over;
  logic [15:0]            hdr_len;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    wr_en     = 1'b0;
    wr_addr   = ptr_q;
    wr_data   = in_data;
    hdr_over  = (in_data > MAX_LEN16);
    hdr_len   = hdr_over ? MAX_LEN16 : in_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_HDR;
          len_err_d = 1'b0;
        end
      end

      S_HDR: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          wr_data = hdr_len;
          len_d   = AW'(hdr_len);
          ptr_d   = PTR_ONE;
          if (hdr_over) len_err_d = 1'b1;
          if (hdr_len == 16'h0000) begin
`ifdef PROG_LOADER_CLEAR_EN
            state_d = S_CLEAR;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (ptr_q == len_q) begin
`ifdef PROG_LOADER_CLEAR_EN
            // A full-length image has no tail; the pointer must not step past the last word.
            if (len_q == PTR_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CLEAR;
              ptr_d   = ptr_q + PTR_ONE;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end

`ifdef PROG_LOADER_CLEAR_EN
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_data = '0;
        if (ptr_q == PTR_LAST) state_d = S_DONE;
        else                   ptr_d   = ptr_q + PTR_ONE;
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered decodes of the next state, so they never depend combinationally on in_valid.
    in_ready_d     = (state_d == S_HDR) || (state_d == S_LOAD);
    prog_loading_d = (state_d != S_IDLE);
    load_done_d    = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      len_q          <= '0;
      len_err_q      <= 1'b0;
      in_ready_q     <= 1'b0;
      prog_loading_q <= 1'b0;
      load_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      len_q          <= len_d;
      len_err_q      <= len_err_d;
      in_ready_q     <= in_ready_d;
      prog_loading_q <= prog_loading_d;
      load_done_q    <= load_done_d;
    end
  end

  // NOTE: the image is a flop array, not RAM, because reset must zero every word at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      img_q <= '0;
    end else if (wr_en) begin
      img_q[wr_addr] <= wr_data;
    end
  end

  assign in_ready        = in_ready_q;
  assign prog_loading    = prog_loading_q;
  assign load_done       = load_done_q;
  assign len_err         = len_err_q;
  assign data_frames_out = img_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a per-cycle transaction model compared on every falling edge,
// plus hand-computed literal checks. Honours PROG_LOADER_CLEAR_EN the same way the design does.
module tb_prog_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef PROG_LOADER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic                   clk      = 1'b0;
  logic                   reset    = 1'b0;
  logic                   start    = 1'b0;
  logic                   in_valid = 1'b0;
  logic [15:0]            in_data  = 16'h0000;
  logic                   in_ready;
  logic                   prog_loading;
  logic                   load_done;
  logic                   len_err;
  logic [DEPTH-1:0][15:0] data_frames_out;

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .prog_loading    (prog_loading),
    .data_frames_out (data_frames_out),
    .load_done       (load_done),
    .len_err         (len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: image contents plus what the loader owes the stream (header, payload count, tail to clear).
  logic [15:0] m_img [DEPTH];
  bit m_ready, m_loading, m_done, m_len_err, m_hdr;
  int m_left, m_wp, m_clr_left, m_len;

  task automatic model_reset();
    foreach (m_img[i]) m_img[i] = 16'h0000;
    m_ready = 0; m_loading = 0; m_done = 0; m_len_err = 0; m_hdr = 0;
    m_left = 0; m_wp = 0; m_clr_left = 0; m_len = 0;
  endtask

  task automatic model_edge();
    if (m_done) begin
      m_done    = 0;
      m_loading = 0;
    end else if (!m_loading) begin
      if (start) begin
        m_loading = 1; m_ready = 1; m_hdr = 1; m_len_err = 0;
      end
    end else if (m_ready && in_valid) begin
      if (m_hdr) begin
        m_len = int'(in_data);
        if (m_len > DEPTH - 1) begin
          m_len     = DEPTH - 1;
          m_len_err = 1;
        end
        m_img[0] = 16'(m_len);
        m_hdr    = 0;
        m_left   = m_len;
        m_wp     = 1;
      end else begin
        m_img[m_wp] = in_data;
        m_wp++;
        m_left--;
      end
      if (m_left == 0) begin
        m_ready    = 0;
        m_clr_left = CLR ? (DEPTH - 1 - m_len) : 0;
        if (m_clr_left == 0) m_done = 1;
      end
    end else if (m_clr_left > 0) begin
      m_img[m_wp] = 16'h0000;
      m_wp++;
      m_clr_left--;
      if (m_clr_left == 0) m_done = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_edge();
    end
  end

  task automatic check_image();
    int bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && data_frames_out[i] !== m_img[i]) bad = i;
    if (bad < 0) check("image", 32'(data_frames_out[0]), 32'(m_img[0]));
    else         check($sformatf("image[%0d]", bad), 32'(data_frames_out[bad]), 32'(m_img[bad]));
  endtask

  bit cmp_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("in_ready",     32'(in_ready),     32'(m_ready));
        check("prog_loading", 32'(prog_loading), 32'(m_loading));
        check("load_done",    32'(load_done),    32'(m_done));
        check("len_err",      32'(len_err),      32'(m_len_err));
        check_image();
      end
    end
  end

  int load_cycles = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (prog_loading) load_cycles++;
    end
  end

  // All drives happen 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input int max_gap);
    int  gap;
    int  waited;
    bit  acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    acc      = 0;
    do begin
      acc = in_ready;
      tick();
      waited++;
    end while (!acc && waited < 50);
    if (!acc) timeout_fail("accept");
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (prog_loading && n < budget) begin
      tick();
      n++;
    end
    if (prog_loading) timeout_fail("idle");
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    reset  = 1'b1;
    cmp_en = 1;
    tick();

    // Reset state and in_valid ignored in IDLE.
    check("rst_loading", 32'(prog_loading), 32'h0);
    check("rst_word0",   32'(data_frames_out[0]), 32'h0);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (4) tick();
    check("idle_ready", 32'(in_ready), 32'h0);
    check("idle_word0", 32'(data_frames_out[0]), 32'h0);
    in_valid = 1'b0;

    // Back-to-back load of a short program.
    do_start();
    check("start_ready",   32'(in_ready),     32'h1);
    check("start_loading", 32'(prog_loading), 32'h1);
    send_word(16'h0003, 0);
    send_word(16'h000F, 0);
    send_word(16'h000F, 0);
    send_word(16'h1234, 0);
    check("done_pulse",      32'(load_done),    32'h1);
    check("done_loading_hi", 32'(prog_loading), 32'h1);
    tick();
    check("done_pulse_end", 32'(load_done),    32'h0);
    check("loading_fell",   32'(prog_loading), 32'h0);
    check("w0", 32'(data_frames_out[0]), 32'h0003);
    check("w1", 32'(data_frames_out[1]), 32'h000F);
    check("w2", 32'(data_frames_out[2]), 32'h000F);
    check("w3", 32'(data_frames_out[3]), 32'h1234);
    check("len_err_short", 32'(len_err), 32'h0);

    // Same stream with random gaps, start held high mid-load (must be ignored).
    do_start();
    send_word(16'h0003, 3);
    start = 1'b1;
    send_word(16'h000F, 3);
    send_word(16'h000F, 3);
    start = 1'b0;
    send_word(16'h1234, 3);
    wait_idle(20);
    check("gap_w1", 32'(data_frames_out[1]), 32'h000F);
    check("gap_w3", 32'(data_frames_out[3]), 32'h1234);

    // Oversized header: clamped to DEPTH-1, len_err set, full image written.
    do_start();
    send_word(16'h0500, 0);
    check("ovf_len_err", 32'(len_err),             32'h1);
    check("ovf_word0",   32'(data_frames_out[0]), 32'h03FF);
    for (int i = 1; i < DEPTH; i++) send_word(16'(i) ^ 16'hA5A5, (i % 7 == 0) ? 2 : 0);
    check("ovf_ready_drop", 32'(in_ready),  32'h0);
    check("ovf_done",       32'(load_done), 32'h1);
    wait_idle(20);
    check("ovf_len_err_sticky", 32'(len_err), 32'h1);
    check("ovf_w1023", 32'(data_frames_out[1023]), 32'hA65A);

    // Short reload over the full image: tail cleared or retained.
    load_cycles = 0;
    do_start();
    send_word(16'h0001, 0);
    send_word(16'hBEEF, 0);
    wait_idle(2000);
    check("reload_cycles",  32'(load_cycles),           CLR ? 32'd1025 : 32'd3);
    check("reload_len_err", 32'(len_err),               32'h0);
    check("reload_w0",      32'(data_frames_out[0]),    32'h0001);
    check("reload_w1",      32'(data_frames_out[1]),    32'hBEEF);
    check("reload_w2",      32'(data_frames_out[2]),    CLR ? 32'h0 : 32'hA5A7);
    check("reload_w1023",   32'(data_frames_out[1023]), CLR ? 32'h0 : 32'hA65A);

    // Reset in the middle of a load at ptr=5, then a normal load.
    do_start();
    send_word(16'h0008, 0);
    for (int i = 1; i <= 4; i++) send_word(16'h0100 + 16'(i), 0);
    check("pre_rst_w4", 32'(data_frames_out[4]), 32'h0104);
    reset = 1'b0;
    #1;
    check("mid_rst_ready",   32'(in_ready),           32'h0);
    check("mid_rst_loading", 32'(prog_loading),       32'h0);
    check("mid_rst_w0",      32'(data_frames_out[0]), 32'h0);
    check("mid_rst_w4",      32'(data_frames_out[4]), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    do_start();
    send_word(16'h0002, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    wait_idle(2000);
    check("post_rst_w0", 32'(data_frames_out[0]), 32'h0002);
    check("post_rst_w2", 32'(data_frames_out[2]), 32'h2222);
    check("post_rst_w4", 32'(data_frames_out[4]), 32'h0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Front-end program loader feeding the scheduler's `data_frames_in` image and its `prog_loading` qualifier. It accepts a header-prefixed stream of 16-bit words over a valid/ready handshake and writes them into a DEPTH×16 register image, exposed in parallel. `prog_loading` stays high for the whole load, so the scheduler only samples the image once it is complete. Optionally, the loader zero-fills the unused tail of the image before releasing it.

## Interface
- `DEPTH`, 1024, number of 16-bit words in the program image (power of two, ≥ 2)
- `AW`, `$clog2(DEPTH)`, address width
- `clk` in 1 — sole clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low reset
- `start` in 1 — single-cycle request to begin a new load; honoured only in IDLE
- `in_valid` in 1 — stream word valid
- `in_ready` out 1 — loader can accept a word this cycle
- `in_data` in 16 — stream word
- `prog_loading` out 1 — image being (re)written; drives scheduler `prog_loading`
- `data_frames_out` out DEPTH×16 — program image, word i at `[i]`; drives scheduler `data_frames_in`
- `load_done` out 1 — one-cycle pulse when the image becomes valid
- `len_err` out 1 — sticky; header length exceeded DEPTH-1 in the last load

## Operation
- States: IDLE, HDR, LOAD, CLEAR (only with macro), DONE.
- IDLE: `in_ready`=0. On `start`=1, go to HDR. Set `prog_loading`=1 and clear `len_err`.
- HDR: `in_ready`=1. On accept, write `in_data` to word 0 and latch LEN = `in_data`.
  - If LEN > DEPTH-1: clamp LEN to DEPTH-1, set `len_err`, and store the clamped value in word 0.
  - If LEN=0, go to DONE (or to CLEAR if the macro is defined). Otherwise set ptr=1 and go to LOAD.
- LOAD: `in_ready`=1. On each accept, write `in_data` to word ptr and increment ptr.
  - When the word at ptr==LEN is accepted, go to DONE (or to CLEAR).
  - `in_valid` gaps simply stall; no timeout.
- CLEAR: `in_ready`=0. Write 0 to word ptr, one word per cycle, until ptr==DEPTH-1 is written, then go to DONE. Skip CLEAR when LEN==DEPTH-1.
- DONE: one cycle. `load_done`=1, `prog_loading`→0, then return to IDLE.
- `start` outside IDLE is ignored. `in_valid` in IDLE, CLEAR, or DONE is ignored and no data is consumed.
- Words that are not overwritten keep their previous contents (no-macro build).
- Pointer arithmetic is AW bits. ptr never wraps, because LEN ≤ DEPTH-1.

## Timing
- Reset (`reset`=0, async) sets: state=IDLE, ptr=0, LEN=0, every image word=0, `prog_loading`=0, `in_ready`=0, `load_done`=0, `len_err`=0.
- Reset mid-load aborts immediately, and the image is zeroed.
- `start` sampled at edge t: `prog_loading`=1 and `in_ready`=1 from t+1.
- Word accepted at edge t appears on `data_frames_out` from t+1.
- Last payload word accepted at edge t (no CLEAR): DONE during t+1 with `load_done`=1. `prog_loading`=0 from t+2.
- With CLEAR: add DEPTH-1-LEN cycles before DONE.
- Throughput is one word per cycle. `in_ready` is a registered state decode and does not depend on `in_valid`.

## Configuration
- `PROG_LOADER_CLEAR_EN` defined: the CLEAR state is compiled in. After every load, words LEN+1..DEPTH-1 read 0 before `prog_loading` falls.
- Not defined: no CLEAR state. Tail words retain stale contents, and the load finishes right after the last payload word.

## Test plan
- Reset then idle: all outputs 0 and the image all-zero. Drive `in_valid`=1 without `start` → `in_ready` stays 0 and no write occurs.
- `start`, then stream 0x0003, 0x000F, 0x000F, 0x1234 back-to-back:
  - words 0..3 = 3, F, F, 1234.
  - `load_done` pulses 1 cycle after the last accept, and `prog_loading` falls the cycle after.
  - `len_err`=0.
- Same stream with random `in_valid` gaps → identical image. Also check that no accept happens when `in_valid`=0.
- Header 0x0500 with DEPTH=1024 → `len_err`=1 and word 0=0x03FF. The load ends after 1023 payload words, and `in_ready` drops.
- Second load with header 0x0001 after a full load:
  - with `PROG_LOADER_CLEAR_EN`, words 2..1023=0 and `prog_loading` stays high 1022 extra cycles.
  - without it, the old words persist.
- Assert `reset`=0 during LOAD at ptr=5 → everything is immediately 0 and state is IDLE. A following `start` and header are accepted normally.
